mdu: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage MIPS core. It executes the HI/LO-class operations flagged by the ID-stage decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It owns the HI and LO architectural registers. It stalls the pipeline while a multi-cycle operation is in flight.

---
 rtl/mdu.sv | 170 +++++++++++++++++
 tb/tb_mdu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// HI/LO multiply-divide unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO for the EX stage.
// Latency: MULT 3 cycles to visible HI/LO, DIV 34 cycles, MTHI/MTLO 1 cycle, MFHI/MFLO combinational.
// Backpressure: combinational stall holds PC/IF/ID/EX while a mult/div is in flight; flush aborts.
module mdu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        flush,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [1:0]  hiloren,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic         w_go;
    logic         w_res_we;
    logic         w_mt_we;

    logic [31:0]  r_a;
    logic [31:0]  r_b;
    logic         r_sign;
    logic [31:0]  r_dvs;
    logic [31:0]  r_rem;
    logic [31:0]  r_quo;
    logic [4:0]   r_cnt;
    logic [63:0]  r_res;
    logic [31:0]  r_hi;
    logic [31:0]  r_lo;

    logic [31:0]  w_abs_a;
    logic [31:0]  w_abs_b;
    logic [32:0]  w_ma;
    logic [32:0]  w_mb;
    logic signed [65:0] w_prod;
    logic [32:0]  w_shift;
    logic [32:0]  w_diff;
    logic         w_fits;
    logic [31:0]  w_rem_nx;
    logic [31:0]  w_quo_nx;
    logic [31:0]  w_q_fix;
    logic [31:0]  w_r_fix;
    logic         w_unused;

    assign w_go = en & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go && mult)     w_next = S_MUL;
                else if (w_go && div) w_next = S_DIV;
            end
            S_MUL:   w_next = flush ? S_IDLE : S_DONE;
            S_DIV:   w_next = flush ? S_IDLE : ((r_cnt == 5'd31) ? S_DONE : S_DIV);
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        w_res_we = 1'b0;
        w_mt_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall   = w_go & (mult | div);
                w_mt_we = w_go & ~(mult | div) & (|hilowen);
            end
            S_MUL, S_DIV: stall = w_go & (mult | div);
            S_DONE:       w_res_we = ~flush;
            default:      stall = 1'b0;
        endcase
        // Reset forces stall low even while the decoder still presents a mult/div.
        if (!resetn) stall = 1'b0;
    end

    assign w_abs_a = (mdsign & rega[31]) ? (~rega + 32'd1) : rega;
    assign w_abs_b = (mdsign & regb[31]) ? (~regb + 32'd1) : regb;

    assign w_ma   = {r_sign & r_a[31], r_a};
    assign w_mb   = {r_sign & r_b[31], r_b};
    assign w_prod = $signed(w_ma) * $signed(w_mb);

    // One restoring step: partial remainder is always below the divisor, so 33 bits suffice.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_fits   = ~w_diff[32];
    assign w_rem_nx = w_fits ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx = {r_quo[30:0], w_fits};

    assign w_q_fix = (r_dvs == 32'd0)               ? 32'hFFFF_FFFF :
                     (r_sign & (r_a[31] ^ r_b[31])) ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_r_fix = (r_dvs == 32'd0)               ? r_a :
                     (r_sign & r_a[31])             ? (~w_rem_nx + 32'd1) : w_rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_res  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go && (mult || div)) begin
                        r_a    <= rega;
                        r_b    <= regb;
                        r_sign <= mdsign;
                        r_dvs  <= w_abs_b;
                        r_quo  <= w_abs_a;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_MUL: begin
                    if (!flush) r_res <= w_prod[63:0];
                end
                S_DIV: begin
                    if (!flush) begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) r_res <= {w_r_fix, w_q_fix};
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_res_we) begin
            r_hi <= r_res[63:32];
            r_lo <= r_res[31:0];
        end else if (w_mt_we) begin
            if (hilowen[1]) r_hi <= rega;
            if (hilowen[0]) r_lo <= rega;
        end
    end

    assign hi         = r_hi;
    assign lo         = r_lo;
    assign hilo_rdata = hiloren[1] ? r_hi : r_lo;

    assign w_unused = &{1'b0, hiloren[0], w_prod[65:64]};

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed test-plan cases, random ops against a behavioural model,
// flush/reset aborts and MTHI/MFHI paths.
module tb_mdu;

    logic        clk;
    logic        resetn;
    logic        en;
    logic        flush;
    logic        mult;
    logic        div;
    logic        mdsign;
    logic [1:0]  hilowen;
    logic [1:0]  hiloren;
    logic [31:0] rega;
    logic [31:0] regb;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;
    logic [63:0] sb[$];

    mdu dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .flush      (flush),
        .mult       (mult),
        .div        (div),
        .mdsign     (mdsign),
        .hilowen    (hilowen),
        .hiloren    (hiloren),
        .rega       (rega),
        .regb       (regb),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic m, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        int     q;
        int     r;
        logic [63:0] res;
        if (m) begin
            pa  = s ? longint'(int'(a)) : longint'({32'd0, a});
            pb  = s ? longint'(int'(b)) : longint'({32'd0, b});
            res = 64'(pa * pb);
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = {32'd0, 32'h8000_0000};
        end else if (s) begin
            q   = int'(a) / int'(b);
            r   = int'(a) % int'(b);
            res = {32'(r), 32'(q)};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    // All tasks start and end at a falling edge.
    task automatic idle();
        en = 1'b0; mult = 1'b0; div = 1'b0; flush = 1'b0;
        hilowen = 2'b00; hiloren = 2'b00;
    endtask

    task automatic mt(input logic [1:0] sel, input logic [31:0] v);
        en = 1'b1; hilowen = sel; rega = v;
        @(negedge clk);
        idle();
    endtask

    // Issue a mult/div, measure the stall length, then compare HI/LO once written.
    task automatic op(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input int exp_stall, input logic [63:0] exp, input string tag);
        int n;
        logic [63:0] e;
        n = 0;
        en = 1'b1; flush = 1'b0; mult = m; div = ~m; mdsign = s;
        hilowen = 2'b11; rega = a; regb = b;
        sb.push_back(exp);
        #1;
        while (stall && n < 60) begin
            n++;
            @(negedge clk);
            rega = $urandom;
            regb = $urandom;
            #1;
        end
        check({tag, "_stall"}, 64'(n), 64'(exp_stall));
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    initial begin
        logic        m;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_fail   = 0;
        resetn = 1'b0;
        idle();
        mdsign = 1'b0; rega = '0; regb = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi",    {32'd0, hi},         64'd0);
        check("rst_lo",    {32'd0, lo},         64'd0);
        check("rst_rdata", {32'd0, hilo_rdata}, 64'd0);
        check("rst_stall", {63'd0, stall},      64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 2, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_s");
        op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 2, {32'h0000_0004, 32'hFFFF_FFF1}, "multu");
        op(1'b0, 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu");
        op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_nega");
        op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, "div_negb");
        op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, "div_ovf");
        op(1'b0, 1'b1, 32'h1234_5678, 32'd0, 33, {32'h1234_5678, 32'hFFFF_FFFF}, "div_zero");
        op(1'b0, 1'b0, 32'h8000_0000, 32'd0, 33, {32'h8000_0000, 32'hFFFF_FFFF}, "divu_zero");
        idle();
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom);
            s = 1'($urandom);
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            op(m, s, a, b, m ? 2 : 33, model(m, s, a, b), "rand");
        end
        idle();
        @(negedge clk);

        mt(2'b10, 32'h1111_1111);
        mt(2'b01, 32'h1111_1111);
        check("mt_hi", {32'd0, hi}, 64'h1111_1111);
        check("mt_lo", {32'd0, lo}, 64'h1111_1111);

        en = 1'b1; div = 1'b1; mdsign = 1'b1; hilowen = 2'b11; rega = 32'd1000; regb = 32'd3;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        idle();
        check("flush_hi", {32'd0, hi}, 64'h1111_1111);
        check("flush_lo", {32'd0, lo}, 64'h1111_1111);
        op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 2, {32'd1, 32'hFFFF_FFFE}, "multu_after_flush");
        idle();
        @(negedge clk);

        en = 1'b1; mult = 1'b1; mdsign = 1'b0; hilowen = 2'b11; rega = 32'd3; regb = 32'd3;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_done_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        idle();
        check("flush_done_hi", {32'd0, hi}, 64'd1);
        check("flush_done_lo", {32'd0, lo}, 64'hFFFF_FFFE);

        en = 1'b1; div = 1'b1; mdsign = 1'b0; hilowen = 2'b11; rega = 32'd50; regb = 32'd5;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_hi",    {32'd0, hi},    64'd0);
        check("arst_lo",    {32'd0, lo},    64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_hi", {32'd0, hi}, 64'd0);
        check("post_rst_lo", {32'd0, lo}, 64'd0);

        mt(2'b10, 32'hA5A5_A5A5);
        hiloren = 2'b10;
        #1;
        check("mfhi", {32'd0, hilo_rdata}, 64'hA5A5_A5A5);
        @(negedge clk);
        mt(2'b01, 32'h5A5A_0F0F);
        hiloren = 2'b01;
        #1;
        check("mflo", {32'd0, hilo_rdata}, 64'h5A5A_0F0F);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
